// File: rtl/replica_pkg.sv
// -----------------------------------------------------------------------------
// replica_pkg
// Shared sizing constants and types for the ordering host bridge.
//   city_div_log : width of the per-node beat count (cmd_num / ordering_num)
//   node_num     : number of nodes served by node_reg
//   node_log     : log2(node_num)
//   total_w      : width of the full-transfer beat counter
//   host_beat_t  : one 64-bit host beat, viewed as 8 bytes
//   bridge_state_t : sequencer states
// -----------------------------------------------------------------------------
package replica_pkg;

  localparam int city_div_log = 4;
  localparam int node_num     = 4;
  localparam int node_log     = 2;
  localparam int total_w      = city_div_log + node_log + 1;

  typedef logic [7:0][7:0] host_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } bridge_state_t;

  // Beats in a whole transfer: (num+1) beats for each node.
  function automatic logic [total_w-1:0] calc_total(input logic [city_div_log-1:0] num);
    return total_w'((total_w'(num) + total_w'(1)) * total_w'(node_num));
  endfunction

endpackage

// File: rtl/ordering_rfifo.sv
// -----------------------------------------------------------------------------
// ordering_rfifo
// First-word-fall-through FIFO of host beats. The head entry is visible on
// rdata_o whenever empty_o is low. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; a pop of an empty FIFO is ignored.
// Ports:
//   clk, rst_n          clock, async active-low reset (pointers only)
//   push_i, wdata_i     write request and data
//   pop_i               remove head entry
//   rdata_o             head entry
//   full_o, empty_o     occupancy flags
// -----------------------------------------------------------------------------
module ordering_rfifo
  import replica_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  host_beat_t wdata_i,
  input  logic       pop_i,
  output host_beat_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  host_beat_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/ordering_host_bridge.sv
// -----------------------------------------------------------------------------
// ordering_host_bridge
// Host-side sequencer in front of node_reg. A command moves (num+1)*node_num
// beats either from the host stream to node_reg (write) or from node_reg to
// the host stream (read).
//
// Handshakes: every interface uses valid/ready; a beat or command transfers on
// a rising edge where both valid and ready are high. Valid never waits on
// ready. ordering_write/ordering_read act as valid towards node_reg, and
// ordering_ready is its ready.
//
// Ports:
//   clk, reset                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_read, cmd_num             direction and beats-per-node minus 1
//   busy, done                    transfer active, 1-cycle completion pulse
//   s_valid/s_ready/s_data        host write beat stream
//   m_valid/m_ready/m_data/m_last host read beat stream
//   ordering_num                  latched cmd_num
//   ordering_write/ordering_wdata write beat request and data
//   ordering_read/ordering_rdata  read beat request, data RD_LAT cycles later
//   ordering_ready                node_reg beat acceptance
//   dbg_state                     current sequencer state
// -----------------------------------------------------------------------------
module ordering_host_bridge
  import replica_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_read,
  input  logic [city_div_log-1:0] cmd_num,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  host_beat_t              s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output host_beat_t              m_data,
  output logic                    m_last,
  output logic [city_div_log-1:0] ordering_num,
  output logic                    ordering_write,
  output host_beat_t              ordering_wdata,
  output logic                    ordering_read,
  input  host_beat_t              ordering_rdata,
  input  logic                    ordering_ready,
  output bridge_state_t           dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  bridge_state_t           state_q, state_d;
  logic [city_div_log-1:0] num_q, num_d;
  logic [total_w-1:0]      total_q, total_d;
  logic [total_w-1:0]      remain_q, remain_d;
  logic [total_w-1:0]      popped_q, popped_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic [RD_LAT-1:0]       pipe_q, pipe_d;
  logic                    done_q, done_d;

  logic       start, issue, pop;
  logic       fifo_full, fifo_empty;
  host_beat_t fifo_head;

  ordering_rfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rfifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (pipe_q[RD_LAT-1]),
    .wdata_i (ordering_rdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ordering_wdata = s_data;
  assign ordering_num   = num_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign dbg_state      = state_q;

  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign pop     = m_valid & m_ready;
  // Head is the final beat once every earlier beat has been popped.
  assign m_last  = m_valid && (popped_q == total_q - total_w'(1));

  always_comb begin
    state_d        = state_q;
    num_d          = num_q;
    total_d        = total_q;
    remain_d       = remain_q;
    done_d         = 1'b0;
    cmd_ready      = 1'b0;
    s_ready        = 1'b0;
    ordering_write = 1'b0;
    ordering_read  = 1'b0;
    start          = 1'b0;
    issue          = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          start    = 1'b1;
          num_d    = cmd_num;
          total_d  = calc_total(cmd_num);
          remain_d = calc_total(cmd_num);
          state_d  = cmd_read ? READ : WRITE;
        end
      end
      WRITE: begin
        ordering_write = s_valid;
        s_ready        = ordering_ready;
        if (s_valid && ordering_ready) begin
          remain_d = remain_q - total_w'(1);
          if (remain_q == total_w'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        // Credit counts FIFO slots not yet claimed by an issued beat, so
        // every beat in the latency pipe already owns a FIFO entry.
        ordering_read = (remain_q != '0) && (credit_q != '0);
        issue         = ordering_read & ordering_ready;
        if (issue) begin
          remain_d = remain_q - total_w'(1);
          if (remain_q == total_w'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last && (pipe_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    popped_d = popped_q;
    credit_d = credit_q;
    if (start) begin
      popped_d = '0;
      credit_d = CW'(FIFO_DEPTH);
    end else begin
      if (pop) popped_d = popped_q + total_w'(1);
      if (issue && !pop) credit_d = credit_q - 1'b1;
      else if (pop && !issue) credit_d = credit_q + 1'b1;
    end
  end

  // Marker pipe mirroring node_reg read latency: bit RD_LAT-1 is set in the
  // cycle ordering_rdata carries the matching beat.
  always_comb begin
    pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      num_q    <= '0;
      total_q  <= '0;
      remain_q <= '0;
      popped_q <= '0;
      credit_q <= CW'(FIFO_DEPTH);
      pipe_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      total_q  <= total_d;
      remain_q <= remain_d;
      popped_q <= popped_d;
      credit_q <= credit_d;
      pipe_q   <= pipe_d;
      done_q   <= done_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(pipe_q[RD_LAT-1] && fifo_full && !pop));

endmodule

// File: tb/tb_ordering_host_bridge.sv
`timescale 1ns/1ps
module tb_ordering_host_bridge;
  import replica_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    cmd_valid, cmd_ready, cmd_read;
  logic [city_div_log-1:0] cmd_num;
  logic                    busy, done;
  logic                    s_valid, s_ready;
  host_beat_t              s_data;
  logic                    m_valid, m_ready, m_last;
  host_beat_t              m_data;
  logic [city_div_log-1:0] ordering_num;
  logic                    ordering_write, ordering_read, ordering_ready;
  host_beat_t              ordering_wdata, ordering_rdata;
  bridge_state_t           dbg_state;

  always #5 clk = ~clk;

  ordering_host_bridge #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_num(cmd_num),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ordering_num(ordering_num), .ordering_write(ordering_write), .ordering_wdata(ordering_wdata),
    .ordering_read(ordering_read), .ordering_rdata(ordering_rdata), .ordering_ready(ordering_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model state ----------------
  bridge_state_t m_st;
  int            m_num, m_total, m_acc, m_iss, m_pop;
  logic          m_done_pend;
  int            issue_cyc[$];
  logic [63:0]   exp_q[$];
  logic [31:0]   rd_tag;
  logic [63:0]   wr_base;

  // node_reg emulation: data scheduled for a future cycle
  logic          sched_v[8];
  logic [63:0]   sched_d[8];

  // observed-event counters (from DUT outputs)
  int wr_seen = 0, rd_seen = 0, iss_seen = 0, acc_seen = 0, done_cnt = 0, ml_cnt = 0, sready_low = 0;
  int first_iss_cyc = -1, first_mv_cyc = -1, last_wr_cyc = 0, done_cyc = 0, ml_cyc = 0, acc_cyc = 0;

  // stimulus knobs
  int ordy_mode = 0;  // 0: always ready, 1: low every 4th cycle, 2: random
  int mr_mode   = 0;  // 0: always ready, 1: random
  int mr_hold   = 0;  // cycles of forced m_ready=0

  function automatic logic [63:0] rd_word(input int k);
    return {rd_tag, 32'(k)};
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_num = 0; m_total = 0; m_acc = 0; m_iss = 0; m_pop = 0;
    m_done_pend = 1'b0;
    issue_cyc.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) sched_v[i] = 1'b0;
  endtask

  // ---------------- input driver for ready/rdata ----------------
  initial begin
    ordering_ready = 1'b0;
    m_ready        = 1'b0;
    ordering_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (ordy_mode)
        0:       ordering_ready = 1'b1;
        1:       ordering_ready = (cyc % 4 != 0);
        default: ordering_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mr_hold > 0) begin
        m_ready = 1'b0;
        mr_hold--;
      end else if (mr_mode == 0) m_ready = 1'b1;
      else m_ready = ($urandom_range(0, 2) != 0);
      if (sched_v[cyc % 8]) ordering_rdata = sched_d[cyc % 8];
      else ordering_rdata = {$urandom, $urandom};
      sched_v[cyc % 8] = 1'b0;
    end
  end

  // ---------------- compare process + model update ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 64'd0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_ordering_num", ordering_num, 0);
      check("rst_ordering_write", ordering_write, 1'b0);
      check("rst_ordering_read", ordering_read, 1'b0);
      check("rst_state", dbg_state, IDLE);
      model_reset();
    end else begin
      int            landed;
      logic          e_mv, e_or, e_ml;
      logic [63:0]   e_md;
      bridge_state_t st_old;

      landed = 0;
      foreach (issue_cyc[i]) if (issue_cyc[i] + RD_LAT < cyc) landed++;
      e_mv = (landed > m_pop) && (exp_q.size() > 0);
      e_or = (m_st == READ) && (m_iss < m_total) && (FIFO_DEPTH - (m_iss - m_pop) > 0);
      e_ml = e_mv && (m_pop == m_total - 1);
      e_md = e_mv ? exp_q[0] : 64'd0;

      check("cmd_ready", cmd_ready, m_st == IDLE);
      check("busy", busy, m_st != IDLE);
      check("done", done, m_done_pend);
      check("s_ready", s_ready, (m_st == WRITE) && ordering_ready);
      check("ordering_write", ordering_write, (m_st == WRITE) && s_valid);
      check("ordering_wdata", ordering_wdata, s_data);
      check("ordering_read", ordering_read, e_or);
      check("m_valid", m_valid, e_mv);
      check("m_last", m_last, e_ml);
      check("m_data", m_data, e_md);
      check("ordering_num", ordering_num, m_num);
      check("state", dbg_state, m_st);

      // observed events
      if (cmd_valid && cmd_ready) begin
        acc_seen++; acc_cyc = cyc; first_iss_cyc = -1; first_mv_cyc = -1; iss_seen = 0;
      end
      if (ordering_read && ordering_ready) begin
        if (first_iss_cyc < 0) first_iss_cyc = cyc;
        sched_v[(cyc + RD_LAT) % 8] = 1'b1;
        sched_d[(cyc + RD_LAT) % 8] = rd_word(iss_seen);
        iss_seen++;
      end
      if (m_valid && busy && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (m_valid && m_ready) begin
        rd_seen++;
        if (m_last) begin ml_cnt++; ml_cyc = cyc; end
      end
      if (ordering_write && ordering_ready) begin wr_seen++; last_wr_cyc = cyc; end
      if (ordering_write && !s_ready) sready_low++;
      if (done) begin done_cnt++; done_cyc = cyc; end

      // model transition for the coming edge
      m_done_pend = 1'b0;
      st_old = m_st;
      case (st_old)
        IDLE: if (cmd_valid) begin
          m_num = int'(cmd_num);
          m_total = (int'(cmd_num) + 1) * node_num;
          m_acc = 0; m_iss = 0; m_pop = 0;
          issue_cyc.delete();
          exp_q.delete();
          if (cmd_read) begin
            rd_tag = $urandom;
            for (int k = 0; k < m_total; k++) exp_q.push_back(rd_word(k));
            m_st = READ;
          end else m_st = WRITE;
        end
        WRITE: if (s_valid && ordering_ready) begin
          check("wdata_order", ordering_wdata, wr_base + 64'(m_acc));
          m_acc++;
          if (m_acc == m_total) begin m_st = IDLE; m_done_pend = 1'b1; end
        end
        default: begin
          if (e_or && ordering_ready) begin
            issue_cyc.push_back(cyc);
            m_iss++;
            if (m_iss == m_total) m_st = DRAIN;
          end
          if (e_mv && m_ready) begin
            void'(exp_q.pop_front());
            m_pop++;
            if (st_old == DRAIN && m_pop == m_total) begin m_st = IDLE; m_done_pend = 1'b1; end
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic send_cmd(input logic rd, input int num);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_read = rd; cmd_num = city_div_log'(num);
    for (int t = 0; t < 400 && !ok; t++) begin
      sample();
      if (cmd_ready) ok = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1'b1);
  endtask

  task automatic write_data(input int n);
    logic ok;
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = wr_base + 64'(i);
      for (int t = 0; t < 100 && !ok; t++) begin
        sample();
        if (s_ready) ok = 1'b1;
        step();
      end
      check("wbeat_accepted", ok, 1'b1);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic got;
    got = 1'b0;
    for (int t = 0; t < budget && !got; t++) begin
      sample();
      if (done) got = 1'b1;
      step();
    end
    check("done_seen", got, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- main sequence ----------------
  int dc0, wr0, rd0, acc0, ml0, sl0;

  initial begin
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_num = '0;
    s_valid = 1'b0; s_data = '0;
    model_reset();
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);

    // 1: write, cmd_num=3, ordering_ready high
    ordy_mode = 0; mr_mode = 0;
    wr_base = {$urandom, 32'h0};
    dc0 = done_cnt; wr0 = wr_seen;
    send_cmd(1'b0, 3);
    write_data(16);
    wait_done(50);
    idle(3);
    check("t1_beats", wr_seen - wr0, 16);
    check("t1_done_once", done_cnt - dc0, 1);
    check("t1_done_latency", done_cyc - last_wr_cyc, 1);
    check("t1_ordering_num", ordering_num, 3);

    // 2: write with ordering_ready low every 4th cycle
    ordy_mode = 1;
    wr_base = {$urandom, 32'h100};
    dc0 = done_cnt; wr0 = wr_seen; sl0 = sready_low;
    send_cmd(1'b0, 3);
    write_data(16);
    wait_done(80);
    idle(2);
    check("t2_beats", wr_seen - wr0, 16);
    check("t2_sready_dropped", (sready_low - sl0) > 0, 1'b1);
    check("t2_done_once", done_cnt - dc0, 1);

    // 3: read, cmd_num=1, m_ready high
    ordy_mode = 0; mr_mode = 0;
    dc0 = done_cnt; rd0 = rd_seen; ml0 = ml_cnt;
    send_cmd(1'b1, 1);
    wait_done(100);
    idle(2);
    check("t3_beats", rd_seen - rd0, 8);
    check("t3_first_latency", first_mv_cyc - first_iss_cyc, RD_LAT + 1);
    check("t3_last_once", ml_cnt - ml0, 1);
    check("t3_done_after_last", done_cyc - ml_cyc, 1);
    check("t3_done_once", done_cnt - dc0, 1);

    // 4: read under 20 cycles of host backpressure
    rd0 = rd_seen;
    mr_hold = 20;
    send_cmd(1'b1, 3);
    for (int t = 0; t < 60 && mr_hold > 0; t++) step();
    sample();
    check("t4_issue_stall", iss_seen, FIFO_DEPTH);
    wait_done(300);
    idle(2);
    check("t4_beats", rd_seen - rd0, 16);

    // 5: reset during the fifth issued beat of a read
    dc0 = done_cnt;
    send_cmd(1'b1, 3);
    for (int t = 0; t < 100 && iss_seen < 5; t++) sample();
    check("t5_reached_beat5", iss_seen, 5);
    #1 reset = 1'b0;
    idle(2);
    #1 reset = 1'b1;
    idle(3);
    check("t5_no_done", done_cnt - dc0, 0);
    check("t5_idle_after_reset", busy, 1'b0);
    wr_base = {$urandom, 32'h200};
    wr0 = wr_seen;
    send_cmd(1'b0, 1);
    write_data(8);
    wait_done(50);
    check("t5_write_after_reset", wr_seen - wr0, 8);

    // 6: cmd_num=0 read with cmd_valid held high
    rd0 = rd_seen; acc0 = acc_seen;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_num = '0;
    for (int t = 0; t < 200; t++) begin
      sample();
      if (acc_seen - acc0 >= 2) break;
      step();
    end
    step();
    cmd_valid = 1'b0;
    check("t6_two_accepts", acc_seen - acc0, 2);
    check("t6_second_on_done", acc_cyc, done_cyc);
    check("t6_first_beats", rd_seen - rd0, 4);
    wait_done(100);
    check("t6_total_beats", rd_seen - rd0, 8);

    // random transfers
    ordy_mode = 2; mr_mode = 1;
    for (int n = 0; n < 8; n++) begin
      logic rd;
      int   num;
      rd  = 1'($urandom_range(0, 1));
      num = $urandom_range(0, 3);
      if (rd) begin
        rd0 = rd_seen;
        send_cmd(1'b1, num);
        wait_done(1000);
        check("rand_rd_beats", rd_seen - rd0, (num + 1) * node_num);
      end else begin
        wr_base = {$urandom, $urandom};
        wr0 = wr_seen;
        send_cmd(1'b0, num);
        write_data((num + 1) * node_num);
        wait_done(100);
        check("rand_wr_beats", wr_seen - wr0, (num + 1) * node_num);
      end
      idle($urandom_range(0, 3));
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
